// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the two requesters plus memory completion and the arbiter.
interface mem_port_arbiter_if;
    logic req_a;
    logic req_b;
    logic done_in;
    logic gnt_a;
    logic gnt_b;
    logic busy;
    logic owner;
    logic timeout_err;

    // Requester/memory side drives requests and completion, observes the grant.
    modport master (
        output req_a,
        output req_b,
        output done_in,
        input  gnt_a,
        input  gnt_b,
        input  busy,
        input  owner,
        input  timeout_err
    );

    // Arbiter side resolves requests into a single registered grant.
    modport slave (
        input  req_a,
        input  req_b,
        input  done_in,
        output gnt_a,
        output gnt_b,
        output busy,
        output owner,
        output timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for one shared memory port.
// A grant is held until completion, withdrawal, or the hold watchdog expires.
// MAX_HOLD must lie in 2..255 and fit in CNT_W bits (2**CNT_W > MAX_HOLD).
module mem_port_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwnA = 2'd1,
        StOwnB = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             last_served_q, last_served_d;  // 0 = A, 1 = B
    logic             owner_q, owner_d;
    logic             timeout_q, timeout_d;
    logic             gnt_a_q, gnt_b_q, busy_q;

    logic own_req;
    logic other_req;
    logic at_limit;
    logic grant_a;
    logic grant_b;

    // Next-state: arbitration in idle, release/handoff decisions while owned.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        last_served_d = last_served_q;
        owner_d       = owner_q;
        timeout_d     = 1'b0;
        grant_a       = 1'b0;
        grant_b       = 1'b0;

        own_req   = (state_q == StOwnB) ? bus.req_b : bus.req_a;
        other_req = (state_q == StOwnB) ? bus.req_a : bus.req_b;
        at_limit  = (hold_cnt_q == HoldLast);

        case (state_q)
            StIdle: begin
                // On a tie the requester not served last wins; completion is ignored here.
                if (bus.req_a && (!bus.req_b || last_served_q)) begin
                    grant_a = 1'b1;
                end else if (bus.req_b) begin
                    grant_b = 1'b1;
                end
            end
            StOwnA, StOwnB: begin
                if (bus.done_in || !own_req || at_limit) begin
                    // Watchdog only counts when neither completion nor withdrawal took priority.
                    timeout_d = !bus.done_in && own_req && at_limit;
                    if (other_req) begin
                        // Direct handoff, no idle bubble.
                        if (state_q == StOwnA) grant_b = 1'b1;
                        else                   grant_a = 1'b1;
                    end else if (own_req && bus.done_in) begin
                        // Back-to-back re-entry for the same owner.
                        if (state_q == StOwnA) grant_a = 1'b1;
                        else                   grant_b = 1'b1;
                    end else begin
                        // Watchdog with only the owner left requesting also lands here,
                        // forcing one idle cycle before re-arbitration.
                        state_d = StIdle;
                    end
                end else if (!at_limit) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Entry into an ownership state restarts the hold window.
        if (grant_a) begin
            state_d       = StOwnA;
            hold_cnt_d    = '0;
            last_served_d = 1'b0;
            owner_d       = 1'b0;
        end else if (grant_b) begin
            state_d       = StOwnB;
            hold_cnt_d    = '0;
            last_served_d = 1'b1;
            owner_d       = 1'b1;
        end
    end

    // State and registered outputs; grants and busy come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            hold_cnt_q    <= '0;
            last_served_q <= 1'b1;
            owner_q       <= 1'b0;
            timeout_q     <= 1'b0;
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            last_served_q <= last_served_d;
            owner_q       <= owner_d;
            timeout_q     <= timeout_d;
            gnt_a_q       <= (state_d == StOwnA);
            gnt_b_q       <= (state_d == StOwnB);
            busy_q        <= (state_d != StIdle);
        end
    end

    assign bus.gnt_a       = gnt_a_q;
    assign bus.gnt_b       = gnt_b_q;
    assign bus.busy        = busy_q;
    assign bus.owner       = owner_q;
    assign bus.timeout_err = timeout_q;

    grant_exclusive_a: assert property (@(posedge clk) disable iff (rst) !(gnt_a_q && gnt_b_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with MAX_HOLD = 4.
// Expected vector per cycle: {gnt_a, gnt_b, busy, owner, timeout_err}.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_HOLD(4),
        .CNT_W   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    string      name_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] observed();
        return {bus.gnt_a, bus.gnt_b, bus.busy, bus.owner, bus.timeout_err};
    endfunction

    task automatic check_now(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = observed();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (ga gb busy own to)", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the response expected after
    // the next rising edge.
    task automatic cyc(input logic ra, input logic rb, input logic dn,
                       input logic [4:0] exp, input string name);
        @(negedge clk);
        bus.req_a   = ra;
        bus.req_b   = rb;
        bus.done_in = dn;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // Monitor: one expected entry is consumed per rising edge while the queue has work.
    initial begin
        logic [4:0] exp;
        string      name;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp  = exp_q.pop_front();
                name = name_q.pop_front();
                check_now(name, exp);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.req_a   = 1'b0;
        bus.req_b   = 1'b0;
        bus.done_in = 1'b0;
        #2;
        check_now("reset_outputs", 5'b00000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single requester: grant one cycle after request, release on completion.
        cyc(1'b0, 1'b0, 1'b0, 5'b00000, "idle_quiet");
        cyc(1'b1, 1'b0, 1'b0, 5'b10100, "grant_a");
        cyc(1'b1, 1'b0, 1'b0, 5'b10100, "hold_a");
        cyc(1'b0, 1'b0, 1'b1, 5'b00000, "done_release_a");
        cyc(1'b0, 1'b0, 1'b0, 5'b00000, "idle_after_a");

        // Tie after A was served: B first, then alternate on every completion.
        cyc(1'b1, 1'b1, 1'b0, 5'b01110, "tie_b_first");
        cyc(1'b1, 1'b1, 1'b1, 5'b10100, "hand_a1");
        cyc(1'b1, 1'b1, 1'b1, 5'b01110, "hand_b1");
        cyc(1'b1, 1'b1, 1'b1, 5'b10100, "hand_a2");
        cyc(1'b1, 1'b1, 1'b1, 5'b01110, "hand_b2");
        cyc(1'b1, 1'b1, 1'b1, 5'b10100, "hand_a3");
        cyc(1'b1, 1'b1, 1'b1, 5'b01110, "hand_b3");
        cyc(1'b0, 1'b0, 1'b1, 5'b00010, "drain_b");

        // Watchdog: B held 4 cycles, timeout pulse with one idle cycle, then re-grant.
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "wd_grant_b");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "wd_hold1");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "wd_hold2");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "wd_hold3");
        cyc(1'b0, 1'b1, 1'b0, 5'b00011, "wd_release");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "wd_regrant");

        // Completion on the watchdog cycle wins: no timeout, back-to-back B.
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "lim_hold1");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "lim_hold2");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "lim_hold3");
        cyc(1'b0, 1'b1, 1'b1, 5'b01110, "done_at_limit");
        // Hold count restarted on re-entry: full window again before the watchdog.
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "b2b_hold1");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "b2b_hold2");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "b2b_hold3");
        cyc(1'b0, 1'b1, 1'b0, 5'b00011, "b2b_wd_release");
        cyc(1'b0, 1'b0, 1'b0, 5'b00010, "idle_owner_kept");

        // Withdraw by A with B waiting: edge-to-edge handoff.
        cyc(1'b1, 1'b0, 1'b0, 5'b10100, "grant_a_w");
        cyc(1'b0, 1'b1, 1'b0, 5'b01110, "withdraw_hand_b");
        cyc(1'b1, 1'b1, 1'b0, 5'b01110, "hold_b_pre_reset");

        // Asynchronous reset between edges while B owns the port.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_now("async_reset_clear", 5'b00000);
        @(negedge clk);
        check_now("reset_held", 5'b00000);
        @(negedge clk);
        rst         = 1'b0;
        bus.req_a   = 1'b1;
        bus.req_b   = 1'b1;
        bus.done_in = 1'b0;
        exp_q.push_back(5'b10100);
        name_q.push_back("post_reset_a_first");
        cyc(1'b1, 1'b1, 1'b1, 5'b01110, "post_reset_hand_b");
        cyc(1'b0, 1'b0, 1'b1, 5'b00010, "final_release");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter for a single shared memory port, e.g. instruction fetch (A) and load/store (B).
- It is the responder side of the request path. Requests combined upstream as ReqA | ReqB are resolved here into exactly one registered grant.
- The grant is held until the memory signals completion, the requester withdraws, or a hold watchdog expires.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- ReqA  input  1  request from requester A; level, held until granted and served.
- ReqB  input  1  request from requester B; same rules as ReqA.
- DoneIn  input  1  memory transaction complete for the current owner; single-cycle pulse.
- GntA  output  1  grant to A, registered.
- GntB  output  1  grant to B, registered.
- Busy  output  1  GntA | GntB, registered.
- Owner  output  1  0 = A, 1 = B; valid only while Busy = 1, holds its last value otherwise.
- TimeoutErr  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- States: IDLE, OWN_A, OWN_B.
  - GntA = (state == OWN_A); GntB = (state == OWN_B).
  - GntA and GntB are never 1 together.
- Reset (asynchronous, any time, including mid-ownership):
  - state = IDLE; GntA = GntB = Busy = Owner = TimeoutErr = 0; HoldCnt = 0.
  - LastServed = B, so A wins the first tie.
- Grant latency: a request sampled in IDLE produces its grant on the next edge (1 cycle).
- IDLE transitions:
  - Only ReqA -> OWN_A.
  - Only ReqB -> OWN_B.
  - Both -> the requester that is not LastServed.
  - Neither -> stay in IDLE.
  - DoneIn is ignored in IDLE.
- On entry to OWN_x: HoldCnt = 0; LastServed = x; Owner = x.
- In OWN_x, HoldCnt increments each cycle; it saturates at MAX_HOLD-1 and never wraps.
- Release conditions, evaluated each cycle in OWN_x, in priority order:
  1. DoneIn = 1.
  2. Reqx = 0 (withdraw/abort).
  3. HoldCnt == MAX_HOLD-1 (watchdog); TimeoutErr = 1 on the following cycle only.
- Next state after a release:
  - Other requester asserting -> OWN_other directly; no IDLE bubble, grant changes hand edge-to-edge.
  - Only x still requesting:
    - If released by DoneIn -> re-enter OWN_x (back-to-back; HoldCnt reset).
    - If released by watchdog -> go to IDLE for one cycle, then re-arbitrate.
  - Nobody requesting -> IDLE.
- If DoneIn and the watchdog hit in the same cycle, DoneIn wins and no TimeoutErr is raised.
- Requests arriving while the other requester owns the port wait; fairness comes from LastServed.
- Maximum wait for a continuously asserting requester: MAX_HOLD cycles plus 1 handoff cycle.
- Busy is registered alongside the grants, so it never glitches on a direct handoff.

Test Plan:
- Reset -> all outputs 0. Assert ReqA at cycle 2 -> GntA = 1 at cycle 3, Owner = 0. DoneIn at cycle 5 with ReqA dropped -> GntA = 0, Busy = 0 at cycle 6.
- ReqA = ReqB = 1 from reset release -> GntA first. DoneIn -> GntB on the next edge with no idle cycle. DoneIn -> GntA again (alternating A, B, A over 6 DoneIn pulses).
- MAX_HOLD = 4, ReqB held, no DoneIn -> GntB for exactly 4 cycles, TimeoutErr pulses once, one IDLE cycle, then GntB re-granted.
- MAX_HOLD = 4: DoneIn on the same cycle HoldCnt = 3 -> no TimeoutErr; with ReqB still high and ReqA low -> back-to-back GntB.
- OWN_A with ReqA dropped and ReqB high -> GntA falls and GntB rises on the same edge; the GntA & GntB overlap assertion never fires.
- Assert Rst mid-OWN_B (asynchronous, between edges) -> grants clear immediately. After release with both requesting -> GntA is granted first.
